// File: rtl/collision_arbiter.sv
// -----------------------------------------------------------------------------
// collision_arbiter
//
// Shares one multi-cycle collision checker between NREQ requesters (Pacman
// turn probe, Pacman line probe, ghosts). Requests are served one at a time.
// The grant is round-robin. The winner's coordinates are captured at grant and
// held on chk_x/chk_y/chk_dir for the whole check. The result comes back to the
// winner as a one-cycle rsp_valid pulse.
//
// Optional feature: define ARB_WATCHDOG_EN to add a WAIT-state watchdog. If
// chk_done does not arrive within TMO cycles, the check is answered with
// rsp_hit = 0 and the sticky tmo_err flag is set.
//
// Ports
//   clk, rst           clock; asynchronous active-high reset
//   req[NREQ]          level request per requester, held until its rsp_valid
//   req_x[NREQ*10]     packed X coordinates, slice i = [10*i+9:10*i]
//   req_y[NREQ*9]      packed Y coordinates, slice i = [9*i+8:9*i]
//   req_dir[NREQ*2]    packed directions (00 up, 01 down, 10 left, 11 right)
//   rsp_valid[NREQ]    one-cycle completion pulse to the granted requester
//   rsp_hit            result, meaningful while rsp_valid != 0 (1 = path clear)
//   chk_start          one-cycle start pulse to the checker
//   chk_x/chk_y/chk_dir registered checker operands
//   chk_done           checker completion pulse (honoured only in WAIT)
//   chk_result         checker result, sampled with chk_done
//   busy               high whenever the arbiter is not IDLE
//   tmo_err            sticky watchdog flag (ARB_WATCHDOG_EN only)
// -----------------------------------------------------------------------------
module collision_arbiter #(
  parameter int NREQ = 4,
  parameter int TMO  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*10-1:0] req_x,
  input  logic [NREQ*9-1:0] req_y,
  input  logic [NREQ*2-1:0] req_dir,
  output logic [NREQ-1:0]   rsp_valid,
  output logic              rsp_hit,
  output logic              chk_start,
  output logic [9:0]        chk_x,
  output logic [8:0]        chk_y,
  output logic [1:0]        chk_dir,
  input  logic              chk_done,
  input  logic              chk_result,
  output logic              busy
`ifdef ARB_WATCHDOG_EN
  ,
  output logic              tmo_err
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Elaboration-time guard on the legal parameter range.
  if (NREQ < 2 || NREQ > 8) begin : g_bad_nreq
    $error("collision_arbiter: NREQ must be in 2..8");
  end
  if (TMO < 1) begin : g_bad_tmo
    $error("collision_arbiter: TMO must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   ptr_reg, ptr_next;
  logic [IW-1:0]   gnt_reg, gnt_next;
  logic            hit_reg, hit_next;
  logic [9:0]      chk_x_reg, chk_x_next;
  logic [8:0]      chk_y_reg, chk_y_next;
  logic [1:0]      chk_dir_reg, chk_dir_next;

`ifdef ARB_WATCHDOG_EN
  localparam int CW = ($clog2(TMO + 1) > 8) ? $clog2(TMO + 1) : 8;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic            tmo_reg, tmo_next;
`endif

  // Unpack the per-requester operand buses.
  logic [9:0] x_arr   [NREQ];
  logic [8:0] y_arr   [NREQ];
  logic [1:0] dir_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign x_arr[gi]   = req_x[10*gi +: 10];
    assign y_arr[gi]   = req_y[9*gi +: 9];
    assign dir_arr[gi] = req_dir[2*gi +: 2];
  end

  // Round-robin pick: the first active request at or after ptr_reg, wrapping.
  logic          found;
  logic [IW-1:0] pick;
  int            idx;

  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_reg) + k) % NREQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = IW'(idx);
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      gnt_reg     <= '0;
      hit_reg     <= 1'b0;
      chk_x_reg   <= '0;
      chk_y_reg   <= '0;
      chk_dir_reg <= '0;
`ifdef ARB_WATCHDOG_EN
      cnt_reg     <= '0;
      tmo_reg     <= 1'b0;
`endif
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      gnt_reg     <= gnt_next;
      hit_reg     <= hit_next;
      chk_x_reg   <= chk_x_next;
      chk_y_reg   <= chk_y_next;
      chk_dir_reg <= chk_dir_next;
`ifdef ARB_WATCHDOG_EN
      cnt_reg     <= cnt_next;
      tmo_reg     <= tmo_next;
`endif
    end
  end

  // Next-state logic
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    gnt_next     = gnt_reg;
    hit_next     = hit_reg;
    chk_x_next   = chk_x_reg;
    chk_y_next   = chk_y_reg;
    chk_dir_next = chk_dir_reg;
`ifdef ARB_WATCHDOG_EN
    cnt_next     = cnt_reg;
    tmo_next     = tmo_reg;
`endif
    case (state_reg)
      ST_IDLE: begin
        if (found) begin
          gnt_next     = pick;
          ptr_next     = (pick == IW'(NREQ - 1)) ? '0 : pick + 1'b1;
          chk_x_next   = x_arr[pick];
          chk_y_next   = y_arr[pick];
          chk_dir_next = dir_arr[pick];
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        state_next = ST_WAIT;
`ifdef ARB_WATCHDOG_EN
        cnt_next   = '0;
`endif
      end
      ST_WAIT: begin
        if (chk_done) begin
          hit_next   = chk_result;
          state_next = ST_RESP;
        end
`ifdef ARB_WATCHDOG_EN
        else if (cnt_reg == CW'(TMO)) begin
          // Give up on the checker: answer "blocked" and flag it.
          hit_next   = 1'b0;
          tmo_next   = 1'b1;
          state_next = ST_RESP;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_rsp
    assign rsp_valid[gi] = (state_reg == ST_RESP) && (gnt_reg == IW'(gi));
  end

  assign rsp_hit   = (state_reg == ST_RESP) && hit_reg;
  assign chk_start = (state_reg == ST_ISSUE);
  assign busy      = (state_reg != ST_IDLE);
  assign chk_x     = chk_x_reg;
  assign chk_y     = chk_y_reg;
  assign chk_dir   = chk_dir_reg;
`ifdef ARB_WATCHDOG_EN
  assign tmo_err   = tmo_reg;
`endif

endmodule

// File: tb/tb_collision_arbiter.sv
// -----------------------------------------------------------------------------
// tb_collision_arbiter
// The bench drives random requests against a transaction-level timing model.
// It also runs directed scenarios with hand-computed expectations.
// Define ARB_WATCHDOG_EN to also exercise the watchdog.
// -----------------------------------------------------------------------------
module tb_collision_arbiter;

  localparam int NREQ = 4;
  localparam int TMO  = 255;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*10-1:0] req_x = '0;
  logic [NREQ*9-1:0]  req_y = '0;
  logic [NREQ*2-1:0]  req_dir = '0;
  logic [NREQ-1:0]    rsp_valid;
  logic               rsp_hit;
  logic               chk_start;
  logic [9:0]         chk_x;
  logic [8:0]         chk_y;
  logic [1:0]         chk_dir;
  logic               chk_done = 1'b0;
  logic               chk_result = 1'b0;
  logic               busy;
`ifdef ARB_WATCHDOG_EN
  logic               tmo_err;
`endif

  collision_arbiter #(.NREQ(NREQ), .TMO(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_x      (req_x),
    .req_y      (req_y),
    .req_dir    (req_dir),
    .rsp_valid  (rsp_valid),
    .rsp_hit    (rsp_hit),
    .chk_start  (chk_start),
    .chk_x      (chk_x),
    .chk_y      (chk_y),
    .chk_dir    (chk_dir),
    .chk_done   (chk_done),
    .chk_result (chk_result),
    .busy       (busy)
`ifdef ARB_WATCHDOG_EN
    ,
    .tmo_err    (tmo_err)
`endif
  );

  initial forever #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- behavioural model (transaction timestamps) ----------------
  // The model does not track FSM states. It records the cycle of each grant
  // (m_start) and the cycle of each accepted completion (m_done). The rules it
  // applies are:
  // - chk_start is high in the grant cycle.
  // - done is honoured from grant+2 onward.
  // - rsp_valid is high in the cycle after done is sampled.
  // - the next grant can happen two cycles after that sample.
  int               m_ptr, m_g, m_start, m_done, m_free;
  bit               m_active, m_res, m_tmo;
  logic [9:0]       m_x;
  logic [8:0]       m_y;
  logic [1:0]       m_dir;

  function automatic int rr_pick(input int ptr, input logic [NREQ-1:0] r);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (ptr + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_step();
    int g;
    if (rst) begin
      m_active = 0; m_ptr = 0; m_g = 0; m_start = -100; m_done = -100;
      m_free = 0; m_res = 0; m_tmo = 0; m_x = '0; m_y = '0; m_dir = '0;
      return;
    end
    if (m_active) begin
      if (cyc >= m_start + 2 && chk_done) begin
        m_active = 0; m_done = cyc; m_res = chk_result; m_free = cyc + 2;
      end
`ifdef ARB_WATCHDOG_EN
      else if (cyc == m_start + TMO + 2) begin
        m_active = 0; m_done = cyc; m_res = 0; m_tmo = 1; m_free = cyc + 2;
      end
`endif
    end else if (cyc >= m_free && req != '0) begin
      g = rr_pick(m_ptr, req);
      m_g = g;
      m_ptr = (g + 1) % NREQ;
      m_x = req_x[10*g +: 10];
      m_y = req_y[9*g +: 9];
      m_dir = req_dir[2*g +: 2];
      m_active = 1;
      m_start = cyc;
    end
  endtask

  // Compare process: inputs are still the ones sampled at the preceding
  // posedge, so the model steps first and the outputs are checked after it.
  initial begin
    logic [NREQ-1:0] exp_rsp;
    forever begin
      @(negedge clk);
      cyc++;
      model_step();
      exp_rsp = '0;
      if (m_done == cyc) exp_rsp[m_g] = 1'b1;
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rsp));
      check("rsp_hit", 32'(rsp_hit), 32'(m_done == cyc && m_res));
      check("chk_start", 32'(chk_start), 32'(m_start == cyc));
      check("busy", 32'(busy), 32'(m_active || m_done == cyc));
      check("chk_x", 32'(chk_x), 32'(m_x));
      check("chk_y", 32'(chk_y), 32'(m_y));
      check("chk_dir", 32'(chk_dir), 32'(m_dir));
`ifdef ARB_WATCHDOG_EN
      check("tmo_err", 32'(tmo_err), 32'(m_tmo));
`endif
      if (rsp_valid != '0)
        $display("txn cycle=%0d rsp_valid=%b hit=%b x=%0d y=%0d dir=%0d",
                 cyc, rsp_valid, rsp_hit, chk_x, chk_y, chk_dir);
    end
  end

  // ---------------- checker responder ----------------
  // resp_delay: 0 = random 1..6 cycles, >0 = fixed, <0 = never respond.
  int resp_delay  = 0;
  bit resp_fixed  = 0;
  bit resp_result = 1;
  bit spurious_en = 0;

  initial begin
    int cd;
    cd = 0;
    forever begin
      @(negedge clk);
      #1;
      chk_done = 1'b0;
      if (chk_start) begin
        if (resp_delay < 0) cd = 0;
        else if (resp_delay == 0) cd = $urandom_range(1, 6);
        else cd = resp_delay;
      end else if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          chk_done   = 1'b1;
          chk_result = resp_fixed ? resp_result : 1'($urandom_range(0, 1));
        end
      end else if (spurious_en && !busy && $urandom_range(0, 15) == 0) begin
        chk_done   = 1'b1;
        chk_result = 1'($urandom_range(0, 1));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    req = '0;
    tick();
    rst = 1'b1;
    tick();
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_chk_start", 32'(chk_start), 32'd0);
    check("rst_chk_x", 32'(chk_x), 32'd0);
    tick();
    rst = 1'b0;
    repeat (8) tick();
  endtask

  task automatic wait_rsp(input string name, output int idx);
    idx = -1;
    for (int n = 0; n < 400; n++) begin
      tick();
      if (rsp_valid != '0) begin
        for (int i = 0; i < NREQ; i++) if (rsp_valid[i]) idx = i;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL %s: no rsp_valid within 400 cycles (cycle %0d)", name, cyc);
  endtask

  function automatic void set_const_coords();
    for (int i = 0; i < NREQ; i++) begin
      req_x[10*i +: 10]  = 10'(100 + i);
      req_y[9*i +: 9]    = 9'(50 + i);
      req_dir[2*i +: 2]  = 2'(i);
    end
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int s_cyc, r_cyc, idx, n;
    int order [8];
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};

    #1 rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single request with result 1, done three cycles after start.
    set_const_coords();
    resp_fixed = 1; resp_result = 1; resp_delay = 3;
    req = 4'b0001;
    r_cyc = cyc;
    tick();
    check("single_start", 32'(chk_start), 32'd1);
    check("single_start_lat", 32'(cyc - r_cyc), 32'd1);
    s_cyc = cyc;
    wait_rsp("single", idx);
    check("single_idx", 32'(idx), 32'd0);
    check("single_rsp_lat", 32'(cyc - s_cyc), 32'd4);
    check("single_hit", 32'(rsp_hit), 32'd1);
    req = '0;

    // Fairness: all requests held high for 8 checks.
    do_reset();
    set_const_coords();
    resp_fixed = 0; resp_delay = 2;
    req = 4'b1111;
    n = 0;
    while (n < 8) begin
      wait_rsp("fair", idx);
      if (idx < 0) break;
      order[n] = idx;
      check("fair_x", 32'(chk_x), 32'(100 + idx));
      check("fair_y", 32'(chk_y), 32'(50 + idx));
      n++;
    end
    req = '0;
    for (int i = 0; i < n; i++) check("fair_order", 32'(order[i]), 32'(exp_order[i]));

    // Operand capture: x changes during WAIT, chk_x keeps the granted value.
    do_reset();
    resp_delay = 5;
    req_x[9:0] = 10'd320;
    req = 4'b0001;
    tick();
    check("cap_start", 32'(chk_start), 32'd1);
    req_x[9:0] = 10'd100;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("cap_chk_x", 32'(chk_x), 32'd320);
    end
    wait_rsp("cap", idx);
    check("cap_idx", 32'(idx), 32'd0);
    req = '0;

    // Reset in the middle of WAIT, then a late chk_done while IDLE.
    do_reset();
    resp_delay = 6;
    req = 4'b1010;
    tick();
    check("rstmid_start", 32'(chk_start), 32'd1);
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("rstmid_async_busy", 32'(busy), 32'd0);
    check("rstmid_async_rsp", 32'(rsp_valid), 32'd0);
    req = '0;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rstmid_no_rsp", 32'(rsp_valid), 32'd0);
      check("rstmid_idle", 32'(busy), 32'd0);
    end
    resp_delay = 0;
    req = 4'b1010;
    wait_rsp("rstmid_next", idx);
    check("rstmid_next_idx", 32'(idx), 32'd1);
    req = '0;

    // Request bit 2 dropped during WAIT still gets its response; ptr moves to 3.
    do_reset();
    resp_delay = 4;
    req = 4'b0100;
    tick();
    tick();
    req[2] = 1'b0;
    wait_rsp("drop", idx);
    check("drop_idx", 32'(idx), 32'd2);
    req = 4'b1111;
    wait_rsp("drop_next", idx);
    check("drop_next_idx", 32'(idx), 32'd3);
    req = '0;

`ifdef ARB_WATCHDOG_EN
    // Watchdog: the checker never answers.
    do_reset();
    resp_delay = -1;
    req = 4'b0001;
    tick();
    check("wd_start", 32'(chk_start), 32'd1);
    s_cyc = cyc;
    wait_rsp("wd", idx);
    check("wd_lat_from_wait", 32'(cyc - (s_cyc + 1)), 32'd256);
    check("wd_hit", 32'(rsp_hit), 32'd0);
    check("wd_tmo", 32'(tmo_err), 32'd1);
    req = '0;
    resp_delay = 0;
    repeat (5) tick();
    check("wd_sticky", 32'(tmo_err), 32'd1);
    do_reset();
    check("wd_cleared", 32'(tmo_err), 32'd0);
`endif

    // Random traffic with spurious dones and occasional async resets.
    do_reset();
    resp_delay = 0;
    resp_fixed = 0;
    spurious_en = 1;
    for (int c = 0; c < 2500; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rsp_valid[i]) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 3) == 0) req[i] = 1'b1;
        else if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
      end
      req_x   = 40'({$urandom(), $urandom()});
      req_y   = 36'({$urandom(), $urandom()});
      req_dir = 8'($urandom());
      if ($urandom_range(0, 299) == 0) begin
        #2 rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    spurious_en = 0;
    req = '0;
    repeat (20) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
